// File: rtl/step_pulse_shaper.sv
// step_pulse_shaper: per-axis step/dir pin driver enforcing setup, high and low widths
module step_pulse_shaper #(
  parameter int CNT_W         = 16,
  parameter int DIR_SETUP_CYC = 100,
  parameter int STEP_HIGH_CYC = 100,
  parameter int STEP_LOW_CYC  = 100,
  parameter int POS_W         = 32,
  parameter bit EN_ACTIVE_LOW = 1'b1
) (
  input  logic             osc_clk,
  input  logic             rst_n,
  input  logic             step_req,
  input  logic             dir_req,
  input  logic             enable_in,
  input  logic             clr_overrun,
  input  logic             pos_load,
  input  logic [POS_W-1:0] pos_value,
  output logic             motor_step,
  output logic             motor_dir,
  output logic             motor_enable,
  output logic             busy,
  output logic             overrun,
  output logic [POS_W-1:0] position
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] HIGH  = 2'd2;
  localparam logic [1:0] LOW   = 2'd3;
  localparam logic [CNT_W-1:0] C_DS = CNT_W'(DIR_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] C_SH = CNT_W'(STEP_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] C_SL = CNT_W'(STEP_LOW_CYC - 1);
  localparam logic EN_OFF = EN_ACTIVE_LOW;
  logic [1:0]       state, nstate;
  logic [CNT_W-1:0] cnt;
  logic             pend, pend_dir, pend_n;
  logic             last_low, take_pend, acc_new, start, sdir, store, drop, rise;
  logic [POS_W-1:0] delta;
  // accept/buffer decisions and next state; a pending request is consumed only
  // at the end of LOW, and a request arriving with the slot full is dropped
  always_comb begin
    last_low  = (state == LOW) && (cnt == '0);
    take_pend = last_low && pend && enable_in;
    acc_new   = enable_in && step_req && ((state == IDLE) || (last_low && !pend));
    start     = take_pend || acc_new;
    sdir      = take_pend ? pend_dir : dir_req;
    store     = enable_in && step_req && !acc_new && !pend;
    drop      = enable_in && step_req && !acc_new && pend;
    pend_n    = !enable_in ? 1'b0 : store ? 1'b1 : take_pend ? 1'b0 : pend;
    nstate    = state;
    case (state)
      IDLE:    nstate = start ? ((sdir != motor_dir) ? SETUP : HIGH) : IDLE;
      SETUP:   nstate = !enable_in ? IDLE : (cnt == '0) ? HIGH : SETUP;
      HIGH:    nstate = (cnt == '0) ? LOW : HIGH;
      default: nstate = !last_low ? LOW : start ? ((sdir != motor_dir) ? SETUP : HIGH) : IDLE;
    endcase
    rise  = (nstate == HIGH) && (state != HIGH);
    delta = motor_dir ? POS_W'(1) : {POS_W{1'b1}};
  end
  // state register and timing counter, reloaded with N-1 on every state entry
  always_ff @(posedge osc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nstate;
      if (nstate != state)
        cnt <= (nstate == SETUP) ? C_DS : (nstate == HIGH) ? C_SH : C_SL;
      else if (cnt != '0)
        cnt <= cnt - CNT_W'(1);
    end
  end
  // registered pins; dir only ever moves on an accept, so hold covers the LOW phase
  always_ff @(posedge osc_clk or negedge rst_n) begin
    if (!rst_n) begin
      motor_step   <= 1'b0;
      motor_dir    <= 1'b0;
      motor_enable <= EN_OFF;
      busy         <= 1'b0;
    end else begin
      motor_step   <= (nstate == HIGH);
      motor_dir    <= start ? sdir : motor_dir;
      motor_enable <= EN_ACTIVE_LOW ? ~enable_in : enable_in;
      busy         <= (nstate != IDLE) || pend_n;
    end
  end
  // one-deep pending slot and sticky overrun flag (a drop beats a same-cycle clear)
  always_ff @(posedge osc_clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= 1'b0;
      pend_dir <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      pend     <= pend_n;
      pend_dir <= store ? dir_req : pend_dir;
      overrun  <= drop ? 1'b1 : clr_overrun ? 1'b0 : overrun;
    end
  end
  // position counts on each rising step edge; an explicit load overrides it
  always_ff @(posedge osc_clk or negedge rst_n) begin
    if (!rst_n) position <= '0;
    else position <= pos_load ? pos_value : rise ? position + delta : position;
  end
endmodule

// File: tb/tb_step_pulse_shaper.sv
// tb_step_pulse_shaper: directed checks of pulse timing, buffering, enable and position
module tb_step_pulse_shaper;
  logic        osc_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        step_req = 1'b0, dir_req = 1'b0, enable_in = 1'b0, clr_overrun = 1'b0, pos_load = 1'b0;
  logic [31:0] pos_value = '0;
  logic        motor_step, motor_dir, motor_enable, busy, overrun;
  logic [31:0] position;
  int          checks = 0, failures = 0, cyc = 0;

  step_pulse_shaper dut (
    .osc_clk(osc_clk), .rst_n(rst_n), .step_req(step_req), .dir_req(dir_req),
    .enable_in(enable_in), .clr_overrun(clr_overrun), .pos_load(pos_load),
    .pos_value(pos_value), .motor_step(motor_step), .motor_dir(motor_dir),
    .motor_enable(motor_enable), .busy(busy), .overrun(overrun), .position(position)
  );

  always #5 osc_clk = ~osc_clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge osc_clk);
      #1;
      cyc++;
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    {step_req, dir_req, enable_in, clr_overrun, pos_load} = '0;
    pos_value = '0;
    tick(2);
    rst_n = 1'b1;
    enable_in = 1'b1;
    tick(1);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 2000 && busy; i++) tick(1);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL %s_idle_timeout busy=%b want 0", name, busy); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    {step_req, dir_req, enable_in, clr_overrun, pos_load} = '0;
    tick(2);
    checks++;
    if ({motor_step, motor_dir, motor_enable, busy, overrun} !== 5'b00100 || position !== 32'd0) begin
      failures++;
      $display("FAIL reset step/dir/en/busy/ovr=%b pos=%h want 00100 pos=0",
               {motor_step, motor_dir, motor_enable, busy, overrun}, position);
    end
    rst_n = 1'b1;
    enable_in = 1'b1;
    tick(1);
    checks++;
    if (motor_enable !== 1'b0) begin failures++; $display("FAIL enable_latency got=%b want 0", motor_enable); end
  endtask

  task automatic test_single_step;
    int n;
    do_reset();
    dir_req = 1'b0; step_req = 1'b1;
    tick(1);
    step_req = 1'b0;
    checks++;
    if (motor_step !== 1'b1 || position !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL single_rise step=%b pos=%h want 1 ffffffff", motor_step, position);
    end
    n = 0;
    while (motor_step && n < 1000) begin n++; tick(1); end
    checks++;
    if (n !== 100) begin failures++; $display("FAIL single_high_width got=%0d want 100", n); end
    tick(99);
    checks++;
    if (busy !== 1'b1 || motor_step !== 1'b0) begin
      failures++; $display("FAIL single_low_busy busy=%b step=%b want 1 0", busy, motor_step);
    end
    tick(1);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL single_idle_at_201 busy=%b want 0", busy); end
  endtask

  task automatic test_dir_setup;
    do_reset();
    dir_req = 1'b1; step_req = 1'b1;
    tick(1);
    step_req = 1'b0;
    checks++;
    if (motor_dir !== 1'b1 || motor_step !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL setup_dir dir=%b step=%b busy=%b want 1 0 1", motor_dir, motor_step, busy);
    end
    tick(99);
    checks++;
    if (motor_step !== 1'b0) begin failures++; $display("FAIL setup_early_step got=%b want 0", motor_step); end
    tick(1);
    checks++;
    if (motor_step !== 1'b1 || position !== 32'd1) begin
      failures++; $display("FAIL setup_rise step=%b pos=%h want 1 00000001", motor_step, position);
    end
    wait_idle("setup");
  endtask

  task automatic test_back_to_back;
    int r1, r2;
    do_reset();
    dir_req = 1'b0; step_req = 1'b1;
    tick(1);
    r1 = cyc;
    tick(1);
    checks++;
    if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_early_overrun got=%b want 0", overrun); end
    tick(1);
    step_req = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin failures++; $display("FAIL b2b_overrun got=%b want 1", overrun); end
    for (int i = 0; i < 1000 && motor_step; i++) tick(1);
    for (int i = 0; i < 1000 && !motor_step; i++) tick(1);
    r2 = cyc;
    checks++;
    if (r2 - r1 !== 200) begin failures++; $display("FAIL b2b_spacing got=%0d want 200", r2 - r1); end
    wait_idle("b2b");
    checks++;
    if (position !== 32'hFFFF_FFFE || overrun !== 1'b1) begin
      failures++; $display("FAIL b2b_pos_sticky pos=%h ovr=%b want fffffffe 1", position, overrun);
    end
    clr_overrun = 1'b1;
    tick(1);
    clr_overrun = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_clear got=%b want 0", overrun); end
  endtask

  task automatic test_enable;
    int n;
    do_reset();
    dir_req = 1'b1; step_req = 1'b1;
    tick(1);
    step_req = 1'b0;
    tick(10);
    enable_in = 1'b0;
    tick(1);
    checks++;
    if (busy !== 1'b0 || motor_enable !== 1'b1) begin
      failures++; $display("FAIL en_abort busy=%b en=%b want 0 1", busy, motor_enable);
    end
    n = 0;
    for (int i = 0; i < 200; i++) begin n += motor_step; tick(1); end
    checks++;
    if (n !== 0 || position !== 32'd0) begin
      failures++; $display("FAIL en_no_pulse high=%0d pos=%h want 0 0", n, position);
    end
    enable_in = 1'b1;
    step_req = 1'b1;
    tick(1);
    step_req = 1'b0;
    enable_in = 1'b0;
    n = 0;
    while (motor_step && n < 1000) begin
      step_req = (n == 5);
      n++;
      tick(1);
    end
    step_req = 1'b0;
    checks++;
    if (n !== 100) begin failures++; $display("FAIL en_full_pulse got=%0d want 100", n); end
    wait_idle("en");
    checks++;
    if (overrun !== 1'b0 || position !== 32'd1) begin
      failures++; $display("FAIL en_ignore ovr=%b pos=%h want 0 00000001", overrun, position);
    end
  endtask

  task automatic test_position;
    do_reset();
    pos_load = 1'b1; pos_value = 32'h7FFF_FFFF;
    tick(1);
    pos_load = 1'b0;
    dir_req = 1'b1; step_req = 1'b1;
    tick(1);
    step_req = 1'b0;
    tick(100);
    checks++;
    if (motor_step !== 1'b1 || position !== 32'h8000_0000) begin
      failures++; $display("FAIL pos_wrap step=%b pos=%h want 1 80000000", motor_step, position);
    end
    wait_idle("pos");
    step_req = 1'b1; pos_load = 1'b1; pos_value = 32'h0000_1234;
    tick(1);
    {step_req, pos_load} = '0;
    checks++;
    if (motor_step !== 1'b1 || position !== 32'h0000_1234) begin
      failures++; $display("FAIL pos_load_prio step=%b pos=%h want 1 00001234", motor_step, position);
    end
    wait_idle("pos2");
  endtask

  task automatic test_async_reset;
    do_reset();
    dir_req = 1'b1; step_req = 1'b1;
    tick(1);
    step_req = 1'b0;
    tick(150);
    checks++;
    if (motor_step !== 1'b1 || motor_dir !== 1'b1) begin
      failures++; $display("FAIL arst_pre step=%b dir=%b want 1 1", motor_step, motor_dir);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({motor_step, motor_dir, motor_enable, busy, overrun} !== 5'b00100 || position !== 32'd0) begin
      failures++;
      $display("FAIL arst_async step/dir/en/busy/ovr=%b pos=%h want 00100 pos=0",
               {motor_step, motor_dir, motor_enable, busy, overrun}, position);
    end
    tick(1);
    rst_n = 1'b1;
    tick(1);
    checks++;
    if (busy !== 1'b0 || motor_step !== 1'b0) begin
      failures++; $display("FAIL arst_release busy=%b step=%b want 0 0", busy, motor_step);
    end
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_dir_setup();
    test_back_to_back();
    test_enable();
    test_position();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
